// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter.
// Contents: FSM state encoding, requester IDs and default widths.
package mem_arb_pkg;

   localparam int DEF_DATA_W  = 8;
   localparam int DEF_ADDR_W  = 8;
   localparam int DEF_MEM_LAT = 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

   typedef enum logic {
      PROC = 1'b0,
      DBG  = 1'b1
   } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker.
// req[0] is the processor and req[1] is debug; on a tie, the requester not named by `last` wins.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      // NOTE: assigning a default before any branch guarantees every path drives gnt, so no latch is inferred.
      gnt = 2'b00;
      if (req == 2'b11) begin
         gnt = (last == DBG) ? 2'b01 : 2'b10;
      end else begin
         gnt = req;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory port between the processor and the debug loader.
// It sequences each access through IDLE -> ACCESS -> RESP.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int MEM_LAT = DEF_MEM_LAT
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              p_req,
   input  logic              p_we,
   input  logic [ADDR_W-1:0] p_addr,
   input  logic [DATA_W-1:0] p_wdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              p_ack,
   output logic [DATA_W-1:0] p_rdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   output logic              m_read,
   output logic              m_write,
   input  logic [DATA_W-1:0] m_rdata,
   output logic [1:0]        ostate,
   output logic              gnt_d
);

   localparam int               CNT_W    = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

   arb_state_e        state_q;
   req_id_e           last_q;
   req_id_e           gnt_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              m_read_q;
   logic              m_write_q;
   logic              p_ack_q;
   logic              d_ack_q;

   logic [1:0]        pick;
   req_id_e           winner;

   rr_arb2 u_rr_arb2 (
      .req  ({d_req, p_req}),
      .last (last_q),
      .gnt  (pick)
   );

   assign winner = req_id_e'(pick[1]);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         last_q    <= DBG;
         gnt_q     <= PROC;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         m_read_q  <= 1'b0;
         m_write_q <= 1'b0;
         p_ack_q   <= 1'b0;
         d_ack_q   <= 1'b0;
      end else begin
         // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
         p_ack_q <= 1'b0;
         d_ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pick != 2'b00) begin
                  last_q    <= winner;
                  gnt_q     <= winner;
                  we_q      <= (winner == DBG) ? d_we    : p_we;
                  addr_q    <= (winner == DBG) ? d_addr  : p_addr;
                  wdata_q   <= (winner == DBG) ? d_wdata : p_wdata;
                  m_read_q  <= (winner == DBG) ? !d_we   : !p_we;
                  m_write_q <= (winner == DBG) ? d_we    : p_we;
                  cnt_q     <= '0;
                  state_q   <= ACCESS;
               end
            end
            ACCESS: begin
               if (we_q) begin
                  m_write_q <= 1'b0;
                  p_ack_q   <= (gnt_q == PROC);
                  d_ack_q   <= (gnt_q == DBG);
                  state_q   <= RESP;
               end else if (cnt_q == CNT_LAST) begin
                  // m_rdata is only guaranteed valid in the final strobe cycle.
                  rdata_q   <= m_rdata;
                  m_read_q  <= 1'b0;
                  p_ack_q   <= (gnt_q == PROC);
                  d_ack_q   <= (gnt_q == DBG);
                  state_q   <= RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               m_read_q  <= 1'b0;
               m_write_q <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   assign m_addr  = addr_q;
   assign m_wdata = wdata_q;
   assign m_read  = m_read_q;
   assign m_write = m_write_q;
   assign p_ack   = p_ack_q;
   assign d_ack   = d_ack_q;
   assign p_rdata = (p_ack_q && !we_q) ? rdata_q : '0;
   assign d_rdata = (d_ack_q && !we_q) ? rdata_q : '0;
   assign ostate  = state_q;
   assign gnt_d   = gnt_q;

endmodule
